// File: rtl/divider.sv
// 32-bit restoring divider: unsigned or signed-floor dividend, unsigned divisor; 32 stall cycles, results in the S==32 cycle.
// The S==0 edge samples the operands and also retires the first quotient bit, so 32 edges produce 32 bits.
module divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        u,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        stall,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic [5:0]  s;
  logic [31:0] r;
  logic [31:0] q;
  logic [31:0] dv;
  logic        sgn;
  logic        xs;

  logic        first;
  logic [31:0] xmag;
  logic [31:0] rin;
  logic [31:0] qin;
  logic [31:0] dvin;
  logic [32:0] t;
  logic        neg;

  assign stall = run & (s != 6'd32);

  always_comb begin
    first = (s == 6'd0);
    xmag  = (u & x[31]) ? (~x + 32'd1) : x;
    rin   = first ? 32'd0 : r;
    qin   = first ? xmag  : q;
    dvin  = first ? y     : dv;
    t     = {rin, qin[31]} - {1'b0, dvin};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s   <= 6'd0;
      r   <= 32'd0;
      q   <= 32'd0;
      dv  <= 32'd0;
      sgn <= 1'b0;
      xs  <= 1'b0;
    end else if (!run) begin
      s <= 6'd0;
    end else if (s != 6'd32) begin
      s <= s + 6'd1;
      if (first) begin
        dv  <= y;
        sgn <= u;
        xs  <= x[31];
      end
      r <= t[32] ? {rin[30:0], qin[31]} : t[31:0];
      q <= {qin[30:0], ~t[32]};
    end
  end

  // Floor correction for negative dividends; divide-by-zero keeps the raw result.
  always_comb begin
    neg  = sgn & xs & (dv != 32'd0);
    quot = q;
    rem  = r;
    if (neg) begin
      if (r == 32'd0) begin
        quot = ~q + 32'd1;
        rem  = 32'd0;
      end else begin
        quot = ~q;
        rem  = dv - r;
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: stall length, results, abort, reset and operand-hold behaviour.
module tb_divider;

  logic        clk;
  logic        rst;
  logic        run;
  logic        u;
  logic [31:0] x;
  logic [31:0] y;
  logic        stall;
  logic [31:0] quot;
  logic [31:0] rem;

  int errors = 0;
  int checks = 0;

  divider dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .u     (u),
    .x     (x),
    .y     (y),
    .stall (stall),
    .quot  (quot),
    .rem   (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles with stall high, sampled mid-cycle, bounded at 100.
  task automatic wait_stall(output int n);
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic finish_req();
    run = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic div_case(input string name, input logic su, input logic [31:0] sx,
                          input logic [31:0] sy, input logic [31:0] eq, input logic [31:0] er);
    int n;
    u = su; x = sx; y = sy; run = 1'b1;
    #1;
    wait_stall(n);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d expected 32", name, n);
    end
    checks++;
    if (quot !== eq || rem !== er) begin
      errors++;
      $display("FAIL %s result: got quot=%h rem=%h expected quot=%h rem=%h", name, quot, rem, eq, er);
    end
    finish_req();
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; u = 1'b0; x = 32'd0; y = 32'd0;
    #1;
    checks++;
    if (stall !== 1'b0 || quot !== 32'd0 || rem !== 32'd0) begin
      errors++;
      $display("FAIL reset_idle: got stall=%b quot=%h rem=%h expected 0 0 0", stall, quot, rem);
    end
    run = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_follows_run: got %b expected 1", stall);
    end
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_unsigned();
    div_case("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    div_case("uffff_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0);
    div_case("u_negx_as_unsigned", 1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1);
  endtask

  task automatic test_signed();
    div_case("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFC, 32'd1);
    div_case("s_m8_2", 1'b1, 32'hFFFFFFF8, 32'd2, 32'hFFFFFFFC, 32'd0);
    div_case("s_min_3", 1'b1, 32'h80000000, 32'd3, 32'hD5555555, 32'd1);
    div_case("s_pos_17_5", 1'b1, 32'd17, 32'd5, 32'd3, 32'd2);
  endtask

  task automatic test_div_zero();
    div_case("u_div0", 1'b0, 32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234);
    div_case("s_div0", 1'b1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'd7);
  endtask

  task automatic test_hold();
    int n;
    logic [31:0] q0;
    u = 1'b0; x = 32'd50; y = 32'd6; run = 1'b1;
    #1;
    wait_stall(n);
    q0 = quot;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b0 || quot !== 32'd8 || rem !== 32'd2 || q0 !== 32'd8) begin
      errors++;
      $display("FAIL hold_after_done: got stall=%b quot=%h rem=%h expected 0 8 2", stall, quot, rem);
    end
    finish_req();
  endtask

  task automatic test_abort();
    u = 1'b0; x = 32'd1000; y = 32'd3; run = 1'b1;
    repeat (10) @(negedge clk);
    run = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL abort_stall_drop: got %b expected 0", stall);
    end
    @(negedge clk);
    #1;
    div_case("abort_then_9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1);
  endtask

  task automatic test_reset_mid();
    int n;
    u = 1'b0; x = 32'd77; y = 32'd10; run = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1 || quot !== 32'd0 || rem !== 32'd0) begin
      errors++;
      $display("FAIL midreset_state: got stall=%b quot=%h rem=%h expected 1 0 0", stall, quot, rem);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    wait_stall(n);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL midreset_stall_cycles: got %0d expected 32", n);
    end
    checks++;
    if (quot !== 32'd7 || rem !== 32'd7) begin
      errors++;
      $display("FAIL midreset_result: got quot=%h rem=%h expected 7 7", quot, rem);
    end
    finish_req();
  endtask

  task automatic test_operand_change();
    int n;
    u = 1'b0; x = 32'd1000; y = 32'd9; run = 1'b1;
    repeat (5) @(negedge clk);
    u = 1'b1; x = 32'hFFFFFFF0; y = 32'd2;
    #1;
    wait_stall(n);
    checks++;
    if (n !== 27) begin
      errors++;
      $display("FAIL opchange_remaining_stall: got %0d expected 27", n);
    end
    checks++;
    if (quot !== 32'd111 || rem !== 32'd1) begin
      errors++;
      $display("FAIL opchange_result: got quot=%h rem=%h expected 6f 1", quot, rem);
    end
    finish_req();
  endtask

  task automatic test_back_to_back();
    div_case("b2b_a", 1'b0, 32'd255, 32'd16, 32'd15, 32'd15);
    div_case("b2b_b", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF1, 32'd5);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_hold();
    test_abort();
    test_reset_mid();
    test_operand_change();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
